pow_m_pipe: RTL
===============

Name: pow_m_pipe

Overview:
- Parametrised complex M-th power engine for Viterbi-Viterbi carrier phase recovery in the coherent DSP datapath.
- Raises N_LANES parallel I/Q samples to the 2nd or 4th power, selected per sample, to strip QPSK/BPSK modulation ahead of the phase averaging filter.
- Fully pipelined with a valid sideband, round-half-up requantisation to a parametrised output Q-format, and overflow handling.

Parameters:
- NBW_IN, 9, input word width per component (signed two's complement).
- NBI_IN, 2, input integer bits incl. sign; F_IN = NBW_IN-NBI_IN fractional bits.
- NBW_OUT, 9, output word width per component.
- NBI_OUT, 2, output integer bits incl. sign; F_OUT = NBW_OUT-NBI_OUT.
- N_LANES, 4, parallel samples per clock.

Ports:
- clk  in  1  clock.
- rst_async_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input samples valid, shared by all lanes.
- i_mode  in  1  0 = square (M=2), 1 = fourth power (M=4); sampled with i_valid.
- i_data_i  in  N_LANES*NBW_IN  I components; lane k at [k*NBW_IN +: NBW_IN].
- i_data_q  in  N_LANES*NBW_IN  Q components, same packing.
- o_valid  out  1  output valid.
- o_data_i  out  N_LANES*NBW_OUT  real part of result, same packing.
- o_data_q  out  N_LANES*NBW_OUT  imaginary part of result.
- o_ovf  out  N_LANES  per-lane overflow flag, qualified by o_valid.

Behaviour:
- Reset (rst_async_n=0, asynchronous): all stage valids, o_valid, o_data_i, o_data_q and o_ovf clear to 0 immediately. Deassertion is synchronised externally. Reset mid-stream discards all in-flight samples; no output is produced for them.
- Pipeline: 3 stages. o_valid(t+3) = i_valid(t). Accepts one sample set per cycle; no backpressure.
- Stage 1, registered only when i_valid=1:
  - a = I^2-Q^2 and b = 2IQ, full precision (2*NBW_IN+1 bits, 2*F_IN frac).
  - mode bit registered alongside.
- Stage 2, registered when stage-1 valid:
  - mode=1: re = a^2-b^2, im = 2ab (4*F_IN frac, width 4*NBW_IN+3).
  - mode=0: a and b are passed through, sign-extended and left-shifted by 2*F_IN to the same frac alignment.
- Stage 3, registered when stage-2 valid:
  - Requantise to F_OUT frac bits: add half output LSB, arithmetic shift right (round half toward +inf).
  - Then range-limit to NBW_OUT bits per Optional Feature.
- Hold: when a stage valid is 0, that stage's data registers hold. o_data_* hold the last valid result while o_valid=0.
- Mode is carried per sample. Mode changes on consecutive cycles are legal and produce no bubble.
- Lanes are independent; all share valid and mode.
- Full-scale corner: I=Q=-2^(NBW_IN-1) is legal. Internal widths must not overflow for any input.

Optional Feature:
- Macro POW_M_SAT_EN.
- Defined: the rounded value is saturated to [-2^(NBW_OUT-1), 2^(NBW_OUT-1)-1]. o_ovf[k]=1 on samples where lane k saturated in either component.
- Undefined: the low NBW_OUT bits of the rounded value are kept (wrap). o_ovf is tied to 0.

Test Plan (defaults; 1 LSB = 1/128):
- Reset: assert rst_async_n=0 mid-stream with 3 samples in flight -> o_valid=0 and outputs 0 within the same cycle. After release, first o_valid appears 3 cycles after the next i_valid.
- Basic, lane 0: I=64, Q=0 -> mode 0 gives (32,0); mode 1 gives (8,0). I=64, Q=64 -> mode 0 gives (0,64); mode 1 gives (-32,0). Each result appears exactly 3 cycles later.
- Rounding: I=8, Q=0, mode 0 -> (1,0), tie rounds up. I=0, Q=8, mode 0 -> (0,0), negative tie rounds toward +inf. I=1, Q=0, mode 0 -> (0,0).
- Saturation (POW_M_SAT_EN): I=255, Q=0, both modes -> o_data_i=255, o_ovf[0]=1. I=-256, Q=0, mode 1 -> 255, o_ovf=1. Without macro, the same inputs give the wrapped low 9 bits and o_ovf=0.
- Streaming: back-to-back i_valid for 20 cycles with alternating mode and random lane data -> every output matches a golden model, in order, with no gaps.
- Gaps: i_valid pattern 1,0,0,1 -> o_valid pattern 1,0,0,1 delayed by 3 cycles. o_data holds its value during the 0 cycles.

Source files
------------

// File: rtl/pow_m_pipe.sv
// Complex M-th power (M = 2 or 4, per sample) over N_LANES I/Q lanes, 3-stage pipeline.
// Define POW_M_SAT_EN to saturate the output and raise o_ovf; otherwise the result wraps.
module pow_m_pipe #(
    parameter int NBW_IN  = 9,
    parameter int NBI_IN  = 2,
    parameter int NBW_OUT = 9,
    parameter int NBI_OUT = 2,
    parameter int N_LANES = 4
) (
    input  logic                         clk,
    input  logic                         rst_async_n,
    input  logic                         i_valid,
    input  logic                         i_mode,
    input  logic [N_LANES*NBW_IN-1:0]    i_data_i,
    input  logic [N_LANES*NBW_IN-1:0]    i_data_q,
    output logic                         o_valid,
    output logic [N_LANES*NBW_OUT-1:0]   o_data_i,
    output logic [N_LANES*NBW_OUT-1:0]   o_data_q,
    output logic [N_LANES-1:0]           o_ovf
);
    localparam int F_IN  = NBW_IN - NBI_IN;
    localparam int F_OUT = NBW_OUT - NBI_OUT;
    localparam int WA    = 2*NBW_IN + 1;
    localparam int WR    = 4*NBW_IN + 3;
    localparam int ALIGN = 2*F_IN;
    localparam int SH    = 4*F_IN - F_OUT;
    localparam logic signed [WR-1:0] HALF = WR'(1) <<< (SH-1);
`ifdef POW_M_SAT_EN
    localparam logic signed [WR-1:0] MAXO = (WR'(1) <<< (NBW_OUT-1)) - WR'(1);
    localparam logic signed [WR-1:0] MINO = ~MAXO;
`endif

    logic                   s1_v_q, s1_m_q, s2_v_q, o_valid_q;
    logic signed [WA-1:0]   s1_a_d [N_LANES];
    logic signed [WA-1:0]   s1_b_d [N_LANES];
    logic signed [WA-1:0]   s1_a_q [N_LANES];
    logic signed [WA-1:0]   s1_b_q [N_LANES];
    logic signed [WR-1:0]   s2_re_d [N_LANES];
    logic signed [WR-1:0]   s2_im_d [N_LANES];
    logic signed [WR-1:0]   s2_re_q [N_LANES];
    logic signed [WR-1:0]   s2_im_q [N_LANES];
    logic [N_LANES*NBW_OUT-1:0] o_di_d, o_dq_d, o_di_q, o_dq_q;
`ifdef POW_M_SAT_EN
    logic [N_LANES-1:0]     ovf_d, ovf_q;
`endif

    // Round half toward +inf: add half an output LSB, then arithmetic shift.
    function automatic logic signed [WR-1:0] round_hu(input logic signed [WR-1:0] v);
        return (v + HALF) >>> SH;
    endfunction

`ifdef POW_M_SAT_EN
    function automatic logic [NBW_OUT-1:0] clamp(input logic signed [WR-1:0] r);
        if (r > MAXO) return NBW_OUT'(MAXO);
        if (r < MINO) return NBW_OUT'(MINO);
        return NBW_OUT'(r);
    endfunction

    function automatic logic out_of_range(input logic signed [WR-1:0] r);
        return (r > MAXO) || (r < MINO);
    endfunction
`endif

    always_comb begin
        logic signed [WA-1:0] xi, xq;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            xi = WA'($signed(i_data_i[k*NBW_IN +: NBW_IN]));
            xq = WA'($signed(i_data_q[k*NBW_IN +: NBW_IN]));
            s1_a_d[k] = xi*xi - xq*xq;
            s1_b_d[k] = (xi*xq) <<< 1;
        end
    end

    // Square mode is moved onto the fourth-power fraction grid so stage 3 has one shift.
    always_comb begin
        logic signed [WR-1:0] ea, eb;
        for (int unsigned k = 0; k < N_LANES; k++) begin
            ea = WR'(s1_a_q[k]);
            eb = WR'(s1_b_q[k]);
            if (s1_m_q) begin
                s2_re_d[k] = ea*ea - eb*eb;
                s2_im_d[k] = (ea*eb) <<< 1;
            end else begin
                s2_re_d[k] = ea <<< ALIGN;
                s2_im_d[k] = eb <<< ALIGN;
            end
        end
    end

    always_comb begin
        o_di_d = '0;
        o_dq_d = '0;
`ifdef POW_M_SAT_EN
        ovf_d  = '0;
`endif
        for (int unsigned k = 0; k < N_LANES; k++) begin
`ifdef POW_M_SAT_EN
            o_di_d[k*NBW_OUT +: NBW_OUT] = clamp(round_hu(s2_re_q[k]));
            o_dq_d[k*NBW_OUT +: NBW_OUT] = clamp(round_hu(s2_im_q[k]));
            ovf_d[k] = out_of_range(round_hu(s2_re_q[k])) | out_of_range(round_hu(s2_im_q[k]));
`else
            o_di_d[k*NBW_OUT +: NBW_OUT] = NBW_OUT'(round_hu(s2_re_q[k]));
            o_dq_d[k*NBW_OUT +: NBW_OUT] = NBW_OUT'(round_hu(s2_im_q[k]));
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            s1_v_q    <= 1'b0;
            s1_m_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            o_valid_q <= 1'b0;
            for (int unsigned k = 0; k < N_LANES; k++) begin
                s1_a_q[k]  <= '0;
                s1_b_q[k]  <= '0;
                s2_re_q[k] <= '0;
                s2_im_q[k] <= '0;
            end
            o_di_q <= '0;
            o_dq_q <= '0;
`ifdef POW_M_SAT_EN
            ovf_q  <= '0;
`endif
        end else begin
            s1_v_q    <= i_valid;
            s2_v_q    <= s1_v_q;
            o_valid_q <= s2_v_q;
            if (i_valid) begin
                s1_m_q <= i_mode;
                for (int unsigned k = 0; k < N_LANES; k++) begin
                    s1_a_q[k] <= s1_a_d[k];
                    s1_b_q[k] <= s1_b_d[k];
                end
            end
            if (s1_v_q) begin
                for (int unsigned k = 0; k < N_LANES; k++) begin
                    s2_re_q[k] <= s2_re_d[k];
                    s2_im_q[k] <= s2_im_d[k];
                end
            end
            if (s2_v_q) begin
                o_di_q <= o_di_d;
                o_dq_q <= o_dq_d;
`ifdef POW_M_SAT_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign o_valid  = o_valid_q;
    assign o_data_i = o_di_q;
    assign o_data_q = o_dq_q;
`ifdef POW_M_SAT_EN
    assign o_ovf    = ovf_q;
`else
    assign o_ovf    = '0;
`endif

endmodule
